// File: rtl/ppu_multilane_pipe_if.sv
// ----------------------------------------------------------------------------
// ppu_multilane_pipe_if
// Bundles the configuration handshake, the input beat stream, the output beat
// stream and the status outputs of the multi-lane post-processing unit.
//
// Modports
//   master : drives cfg_*, in_*, out_ready; observes ready/valid/status.
//   slave  : the PPU side (opposite directions).
//
// Signals
//   cfg_valid/cfg_ready   config handshake
//   cfg_shift[5:0]        right-shift amount
//   cfg_zp[7:0]           unsigned output zero point
//   cfg_act_mode[1:0]     0/3 bypass, 1 ReLU, 2 clamp [0,cfg_act_max]
//   cfg_act_max[7:0]      upper clamp for mode 2
//   in_valid/in_ready     input beat handshake
//   in_data               LANES signed lanes of DATA_BITS each
//   in_last               end-of-tile marker travelling with the beat
//   out_valid/out_ready   output beat handshake
//   out_data              LANES unsigned bytes
//   out_last              delayed in_last
//   sat_cnt               beats with at least one clamped lane
//   busy                  any pipeline stage holds a beat
// ----------------------------------------------------------------------------
interface ppu_multilane_pipe_if #(
    parameter int DATA_BITS = 16,
    parameter int LANES     = 4,
    parameter int CNT_BITS  = 16
);
    logic                         cfg_valid;
    logic                         cfg_ready;
    logic [5:0]                   cfg_shift;
    logic [7:0]                   cfg_zp;
    logic [1:0]                   cfg_act_mode;
    logic [7:0]                   cfg_act_max;
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*DATA_BITS-1:0]   in_data;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES*8-1:0]           out_data;
    logic                         out_last;
    logic [CNT_BITS-1:0]          sat_cnt;
    logic                         busy;

    modport master (
        output cfg_valid, cfg_shift, cfg_zp, cfg_act_mode, cfg_act_max,
        output in_valid, in_data, in_last, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data, out_last, sat_cnt, busy
    );

    modport slave (
        input  cfg_valid, cfg_shift, cfg_zp, cfg_act_mode, cfg_act_max,
        input  in_valid, in_data, in_last, out_ready,
        output cfg_ready, in_ready, out_valid, out_data, out_last, sat_cnt, busy
    );
endinterface

// File: rtl/ppu_multilane_pipe.sv
// ----------------------------------------------------------------------------
// ppu_multilane_pipe
// Requantizes LANES signed accumulator lanes per beat to uint8:
//   arithmetic right shift -> activation -> zero-point add -> clamp [0,255].
// Three-stage elastic pipeline (shift / activation / output) with
// valid/ready backpressure at every stage; 1 beat/cycle when unstalled.
// Configuration is loaded through a handshake only while the pipeline is
// empty, so every beat in flight sees one consistent configuration.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   ppu_multilane_pipe_if.slave (config, input stream, output stream,
//         sat_cnt, busy)
//
// Build option
//   PPU_ROUND_EN  when defined, the shift stage rounds half-up by adding
//                 1<<(shift-1) in DATA_BITS+1 bits before shifting; when
//                 undefined the shift truncates (floor) and no adder exists.
// ----------------------------------------------------------------------------
module ppu_multilane_pipe #(
    parameter int DATA_BITS = 16,
    parameter int LANES     = 4,
    parameter int CNT_BITS  = 16
) (
    input logic                 clk,
    input logic                 rst,
    ppu_multilane_pipe_if.slave bus
);
    localparam int         XW     = DATA_BITS + 1;
    localparam int         YW     = DATA_BITS + 2;
    localparam logic [5:0] SH_MAX = 6'(DATA_BITS - 1);

    // Shift stage arithmetic; sh is already limited to DATA_BITS-1.
    function automatic logic signed [DATA_BITS-1:0] f_shift(
        input logic signed [DATA_BITS-1:0] x,
        input logic [5:0]                  sh
    );
`ifdef PPU_ROUND_EN
        logic signed [XW-1:0] one;
        logic signed [XW-1:0] bias;
        logic signed [XW-1:0] t;
        one  = XW'(1);
        bias = (sh == 6'd0) ? '0 : (one <<< (sh - 6'd1));
        // One extra bit keeps max positive input + bias from wrapping.
        t    = XW'(x) + bias;
        t    = t >>> sh;
        return t[DATA_BITS-1:0];
`else
        return x >>> sh;
`endif
    endfunction

    function automatic logic signed [DATA_BITS-1:0] f_act(
        input logic signed [DATA_BITS-1:0] x,
        input logic [1:0]                  mode,
        input logic [7:0]                  amax
    );
        logic signed [DATA_BITS-1:0] m;
        logic signed [DATA_BITS-1:0] r;
        m = signed'(DATA_BITS'(amax));
        case (mode)
            2'd1:    r = (x < 0) ? '0 : x;
            2'd2:    r = (x < 0) ? '0 : ((x > m) ? m : x);
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic signed [YW-1:0] f_add_zp(
        input logic signed [DATA_BITS-1:0] x,
        input logic [7:0]                  zp
    );
        return YW'(x) + signed'(YW'(zp));
    endfunction

    function automatic logic [7:0] f_sat_u8(input logic signed [YW-1:0] y);
        logic [7:0] r;
        if (y >= 255)     r = 8'hFF;
        else if (y <= 0)  r = 8'h00;
        else              r = y[7:0];
        return r;
    endfunction

    // y == 0 maps to 0 without being a clamp.
    function automatic logic f_clamped(input logic signed [YW-1:0] y);
        return (y >= 255) || (y < 0);
    endfunction

    // Configuration registers
    logic [5:0] shift_q;
    logic [7:0] zp_q;
    logic [1:0] mode_q;
    logic [7:0] act_max_q;

    // Pipeline state
    logic                        vld_p0, vld_p1, vld_p2;
    logic                        last_p0, last_p1, last_p2;
    logic signed [DATA_BITS-1:0] dat_p0 [LANES];
    logic signed [DATA_BITS-1:0] dat_p1 [LANES];
    logic [LANES*8-1:0]          out_p2;
    logic                        clip_p2;
    logic [CNT_BITS-1:0]         sat_cnt_q;

    // Stage inputs
    logic signed [DATA_BITS-1:0] s1_d [LANES];
    logic signed [DATA_BITS-1:0] s2_d [LANES];
    logic signed [YW-1:0]        y_p1 [LANES];
    logic [LANES*8-1:0]          s3_d;
    logic                        s3_clip;

    // Flow control
    logic rdy_p0, rdy_p1, rdy_p2;
    logic ld_p1, ld_p2;
    logic busy_w, in_ready_w, in_fire, cfg_fire;

    assign rdy_p2     = !vld_p2 || bus.out_ready;
    assign rdy_p1     = !vld_p1 || rdy_p2;
    assign rdy_p0     = !vld_p0 || rdy_p1;
    assign ld_p1      = vld_p0 && rdy_p1;
    assign ld_p2      = vld_p1 && rdy_p2;
    assign busy_w     = vld_p0 || vld_p1 || vld_p2;
    // A pending config blocks new beats so the pipeline can drain.
    assign in_ready_w = rdy_p0 && !bus.cfg_valid;
    assign in_fire    = bus.in_valid && in_ready_w;
    assign cfg_fire   = bus.cfg_valid && !busy_w;

    assign bus.cfg_ready = !busy_w;
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = vld_p2;
    assign bus.out_data  = out_p2;
    assign bus.out_last  = last_p2;
    assign bus.sat_cnt   = sat_cnt_q;
    assign bus.busy      = busy_w;

    always_comb begin
        s3_d    = '0;
        s3_clip = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            s1_d[i]          = f_shift(bus.in_data[i*DATA_BITS +: DATA_BITS], shift_q);
            s2_d[i]          = f_act(dat_p0[i], mode_q, act_max_q);
            y_p1[i]          = f_add_zp(dat_p1[i], zp_q);
            s3_d[i*8 +: 8]   = f_sat_u8(y_p1[i]);
            s3_clip          = s3_clip | f_clamped(y_p1[i]);
        end
    end

    // ---- p0: shift result | p1: activation result ----
    always_ff @(posedge clk) begin
        if (in_fire) begin
            dat_p0  <= s1_d;
            last_p0 <= bus.in_last;
        end
        if (ld_p1) begin
            dat_p1  <= s2_d;
            last_p1 <= last_p0;
        end
    end

    // ---- p2: saturated output, valids, config, counter ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_p2    <= '0;
            last_p2   <= 1'b0;
            clip_p2   <= 1'b0;
            sat_cnt_q <= '0;
            shift_q   <= 6'd8;
            zp_q      <= 8'd128;
            mode_q    <= 2'd1;
            act_max_q <= 8'd255;
        end else begin
            if (cfg_fire) begin
                shift_q   <= (bus.cfg_shift > SH_MAX) ? SH_MAX : bus.cfg_shift;
                zp_q      <= bus.cfg_zp;
                mode_q    <= bus.cfg_act_mode;
                act_max_q <= bus.cfg_act_max;
            end
            if (rdy_p0) vld_p0 <= in_fire;
            if (rdy_p1) vld_p1 <= vld_p0;
            if (rdy_p2) vld_p2 <= vld_p1;
            if (ld_p2) begin
                out_p2  <= s3_d;
                last_p2 <= last_p1;
                clip_p2 <= s3_clip;
            end
            // cfg_fire needs an empty pipe, so it never meets an output handshake.
            if (cfg_fire) begin
                sat_cnt_q <= '0;
            end else if (vld_p2 && bus.out_ready && clip_p2 && (sat_cnt_q != '1)) begin
                sat_cnt_q <= sat_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ppu_multilane_pipe.sv
// ----------------------------------------------------------------------------
// tb_ppu_multilane_pipe
// Directed bench for ppu_multilane_pipe with hand-computed expected bytes.
// Covers reset defaults, latency, activation modes, saturation counting,
// a backpressured 64-beat stream, config during drain, shift rounding and
// mid-stream reset.
// ----------------------------------------------------------------------------
module tb_ppu_multilane_pipe;
    localparam int DB = 16;
    localparam int LN = 4;
    localparam int CB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ppu_multilane_pipe_if #(.DATA_BITS(DB), .LANES(LN), .CNT_BITS(CB)) bus ();

    ppu_multilane_pipe #(.DATA_BITS(DB), .LANES(LN), .CNT_BITS(CB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [5:0] sh, input logic [7:0] zp,
                       input logic [1:0] md, input logic [7:0] am);
        int n = 0;
        bus.cfg_valid    = 1'b1;
        bus.cfg_shift    = sh;
        bus.cfg_zp       = zp;
        bus.cfg_act_mode = md;
        bus.cfg_act_max  = am;
        @(negedge clk);
        while (!bus.cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cfg_wait", n < 100, 1'b1);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic push(input logic [LN*DB-1:0] d, input logic l);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_wait", n < 100, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pull(output logic [LN*8-1:0] d, output logic l, output int lat);
        lat = 0;
        bus.out_ready = 1'b1;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 50);
        chk("pull_wait", lat < 50, 1'b1);
        d = bus.out_data;
        l = bus.out_last;
        @(posedge clk); #1;
    endtask

    function automatic logic [LN*DB-1:0] vec4(input int n);
        logic [LN*DB-1:0] v;
        for (int l = 0; l < LN; l++) v[l*DB +: DB] = 16'((4*n + l) & 255);
        return v;
    endfunction

    function automatic logic [LN*8-1:0] exp4(input int n);
        logic [LN*8-1:0] v;
        for (int l = 0; l < LN; l++) v[l*8 +: 8] = 8'((4*n + l) & 255);
        return v;
    endfunction

    logic [LN*8-1:0] od;
    logic            ol;
    int              lat;
    int              ntx, nrx, cyc;
    logic            txf, cf, inf, blk_bad;
    logic [LN*8-1:0] got [4];

    initial begin
        bus.cfg_valid = 1'b0; bus.cfg_shift = '0; bus.cfg_zp = '0;
        bus.cfg_act_mode = '0; bus.cfg_act_max = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Reset state
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data",  bus.out_data, '0);
        chk("rst_out_last",  bus.out_last, 1'b0);
        chk("rst_sat_cnt",   bus.sat_cnt, '0);
        chk("rst_busy",      bus.busy, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_cfg_ready", bus.cfg_ready, 1'b1);
        chk("idle_in_ready",  bus.in_ready, 1'b1);

        // 1: defaults shift 8, zp 128, ReLU
        push({4{16'sh0500}}, 1'b1);
        pull(od, ol, lat);
        chk("t1_latency", lat, 3);
        chk("t1_data",    od, 32'h85858585);
        chk("t1_last",    ol, 1'b1);
        push({4{16'shFB00}}, 1'b0);
        pull(od, ol, lat);
        chk("t1_relu",    od, 32'h80808080);
        chk("t1_last0",   ol, 1'b0);
        chk("t1_sat",     bus.sat_cnt, 0);

        // 2: bypass; -128+128 lands exactly on 0 (not a clamp), 127+128 clamps high
        cfg(6'd8, 8'd128, 2'd0, 8'd255);
        push({4{16'sh8000}}, 1'b0);
        pull(od, ol, lat);
        chk("t2_min",      od, 32'h00000000);
        chk("t2_sat_y0",   bus.sat_cnt, 0);
        push({4{16'sh7FFF}}, 1'b0);
        pull(od, ol, lat);
        chk("t2_max",      od, 32'hFFFFFFFF);
        chk("t2_sat_hi",   bus.sat_cnt, 1);

        // Shift 63 limits to 15; lanes {0xC000,0x4000,0x7FFF,0x8000}
        cfg(6'd63, 8'd0, 2'd0, 8'd255);
        chk("t2_sat_clear", bus.sat_cnt, 0);
        push({16'shC000, 16'sh4000, 16'sh7FFF, 16'sh8000}, 1'b0);
        pull(od, ol, lat);
`ifdef PPU_ROUND_EN
        chk("t2_shmax",    od, 32'h00010100);
`else
        chk("t2_shmax",    od, 32'h00000000);
`endif
        chk("t2_sat_lo",   bus.sat_cnt, 1);

        // 3: clamp mode, act_max 6, lanes {-3,4,9,6}
        cfg(6'd0, 8'd0, 2'd2, 8'd6);
        push({16'sd6, 16'sd9, 16'sd4, -16'sd3}, 1'b0);
        pull(od, ol, lat);
        chk("t3_clamp",    od, 32'h06060400);
        chk("t3_sat",      bus.sat_cnt, 0);

        // 4: 64-beat stream, identity mapping, random backpressure
        cfg(6'd0, 8'd0, 2'd0, 8'd255);
        ntx = 0; nrx = 0; cyc = 0;
        bus.in_valid = 1'b1; bus.in_data = vec4(0); bus.in_last = 1'b0;
        bus.out_ready = ($urandom_range(0, 1) == 1);
        while (nrx < 64 && cyc < 4000) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk("t4_data", bus.out_data, exp4(nrx));
                if (bus.out_ready) begin
                    chk("t4_last", bus.out_last, nrx == 63);
                    nrx++;
                end
            end
            txf = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (txf) ntx++;
            bus.in_valid  = (ntx < 64);
            bus.in_data   = vec4(ntx);
            bus.in_last   = (ntx == 63);
            bus.out_ready = ($urandom_range(0, 1) == 1);
            cyc++;
        end
        chk("t4_count", nrx, 64);
        chk("t4_sent",  ntx, 64);
        chk("t4_sat",   bus.sat_cnt, 1);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("t4_no_extra", bus.out_valid, 1'b0);

        // 5: config arrives with 3 beats in flight
        bus.out_ready = 1'b0;
        push({4{16'd11}}, 1'b0);
        push({4{16'd22}}, 1'b0);
        push({4{16'd33}}, 1'b0);
        bus.cfg_valid = 1'b1; bus.cfg_shift = 6'd0; bus.cfg_zp = 8'd10;
        bus.cfg_act_mode = 2'd0; bus.cfg_act_max = 8'd255;
        bus.in_valid = 1'b1; bus.in_data = {4{16'd44}}; bus.in_last = 1'b1;
        @(negedge clk);
        chk("t5_cfg_ready", bus.cfg_ready, 1'b0);
        chk("t5_in_ready",  bus.in_ready, 1'b0);
        chk("t5_busy",      bus.busy, 1'b1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        nrx = 0; cyc = 0; blk_bad = 1'b0;
        while (nrx < 4 && cyc < 100) begin
            @(negedge clk);
            if (bus.cfg_valid && bus.in_ready) blk_bad = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                got[nrx] = bus.out_data;
                nrx++;
            end
            cf  = bus.cfg_valid && bus.cfg_ready;
            inf = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (cf)  bus.cfg_valid = 1'b0;
            if (inf) bus.in_valid  = 1'b0;
            cyc++;
        end
        chk("t5_count",  nrx, 4);
        chk("t5_block",  blk_bad, 1'b0);
        chk("t5_b1",     got[0], 32'h0B0B0B0B);
        chk("t5_b2",     got[1], 32'h16161616);
        chk("t5_b3",     got[2], 32'h21212121);
        chk("t5_b4_zp",  got[3], 32'h36363636);
        chk("t5_sat_clr", bus.sat_cnt, 0);

        // 6: shift 4, lanes {8,-24,40,24}
        cfg(6'd4, 8'd128, 2'd0, 8'd255);
        push({16'sd8, -16'sd24, 16'sd40, 16'sd24}, 1'b0);
        pull(od, ol, lat);
`ifdef PPU_ROUND_EN
        chk("t6_round", od, 32'h817F8382);
`else
        chk("t6_round", od, 32'h807E8281);
`endif
        push({4{16'sh7FFF}}, 1'b0);
        pull(od, ol, lat);
        chk("t6_hi",     od, 32'hFFFFFFFF);
        chk("t6_sat",    bus.sat_cnt, 1);

        // Mid-stream reset
        bus.out_ready = 1'b0;
        push({4{16'sh7FFF}}, 1'b0);
        push({4{16'sh7FFF}}, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("rst2_out_valid", bus.out_valid, 1'b0);
        chk("rst2_out_data",  bus.out_data, '0);
        chk("rst2_busy",      bus.busy, 1'b0);
        chk("rst2_sat",       bus.sat_cnt, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        push({4{16'sh0500}}, 1'b0);
        pull(od, ol, lat);
        chk("rst2_defaults", od, 32'h85858585);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
